// File: rtl/vedic_mult_pipe.sv
// Pipelined WIDTH x WIDTH Urdhva-Tiryakbhyam multiplier, valid/ready, signed/unsigned.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_a/in_b/in_signed, out_valid/out_ready/out_p.

module vedic_mul #(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  if (W == 1) begin : g_bit
    assign p = {1'b0, a[0] & b[0]};
  end else if (W == 2) begin : g_cell
    logic c1;
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1   = a[1] & b[0] & a[0] & b[1];
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = a[1] & b[1] & c1;
  end else begin : g_rec
    localparam int H = W / 2;
    logic [W-1:0] ll, hl, lh, hh;
    logic [W:0]   mid;
    vedic_mul #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_mul #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_mul #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
    vedic_mul #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
    // Cross terms summed one bit wider so the carry survives.
    assign mid = {1'b0, hl} + {1'b0, lh};
    assign p   = {hh, ll} + ((2*W)'(mid) << H);
  end
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be a power of 2 and >= 2");
  end

  logic             en;
  logic             a_neg, b_neg;
  logic             s1_v_q, s1_v_d, s1_neg_q, s1_neg_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [WIDTH-1:0] ll, hl, lh, hh;
  logic             s2_v_q, s2_v_d, s2_neg_q, s2_neg_d;
  logic [WIDTH-1:0] s2_ll_q, s2_ll_d, s2_hl_q, s2_hl_d;
  logic [WIDTH-1:0] s2_lh_q, s2_lh_d, s2_hh_q, s2_hh_d;
  logic [WIDTH:0]   mid;
  logic [PW-1:0]    prod;
  logic             out_v_q, out_v_d;
  logic [PW-1:0]    out_p_q, out_p_d;

  // Only the output register can stall; the whole pipe moves together.
  assign en        = ~out_v_q | out_ready;
  assign in_ready  = en;
  assign out_valid = out_v_q;
  assign out_p     = out_p_q;

  assign a_neg = in_signed & in_a[WIDTH-1];
  assign b_neg = in_signed & in_b[WIDTH-1];

  vedic_mul #(.W(H)) u_ll (.a(s1_a_q[H-1:0]), .b(s1_b_q[H-1:0]), .p(ll));
  vedic_mul #(.W(H)) u_hl (.a(s1_a_q[WIDTH-1:H]), .b(s1_b_q[H-1:0]), .p(hl));
  vedic_mul #(.W(H)) u_lh (.a(s1_a_q[H-1:0]), .b(s1_b_q[WIDTH-1:H]), .p(lh));
  vedic_mul #(.W(H)) u_hh (.a(s1_a_q[WIDTH-1:H]), .b(s1_b_q[WIDTH-1:H]), .p(hh));

  assign mid  = {1'b0, s2_hl_q} + {1'b0, s2_lh_q};
  assign prod = {s2_hh_q, s2_ll_q} + (PW'(mid) << H);

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_neg_d = s1_neg_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s2_v_d   = s2_v_q;
    s2_neg_d = s2_neg_q;
    s2_ll_d  = s2_ll_q;
    s2_hl_d  = s2_hl_q;
    s2_lh_d  = s2_lh_q;
    s2_hh_d  = s2_hh_q;
    out_v_d  = out_v_q;
    out_p_d  = out_p_q;
    if (en) begin
      s1_v_d   = in_valid;
      s1_neg_d = a_neg ^ b_neg;
      // -(-2^(W-1)) wraps to 2^(W-1), the correct unsigned magnitude.
      s1_a_d   = a_neg ? -in_a : in_a;
      s1_b_d   = b_neg ? -in_b : in_b;
      s2_v_d   = s1_v_q;
      s2_neg_d = s1_neg_q;
      s2_ll_d  = ll;
      s2_hl_d  = hl;
      s2_lh_d  = lh;
      s2_hh_d  = hh;
      out_v_d  = s2_v_q;
      out_p_d  = s2_neg_q ? -prod : prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      out_v_q <= 1'b0;
      out_p_q <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      out_v_q <= out_v_d;
      out_p_q <= out_p_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_neg_q <= s1_neg_d;
    s1_a_q   <= s1_a_d;
    s1_b_q   <= s1_b_d;
    s2_neg_q <= s2_neg_d;
    s2_ll_q  <= s2_ll_d;
    s2_hl_q  <= s2_hl_d;
    s2_lh_q  <= s2_lh_d;
    s2_hh_q  <= s2_hh_d;
  end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe: directed WIDTH=8 vectors and sequences,
// plus exhaustive throttled sweeps on WIDTH=4 and WIDTH=2 instances.

module tb_vedic_mult_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v8, r8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        v4, r4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        v2, r2, s2, ov2, or2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;

  vedic_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(b8), .in_signed(s8),
    .out_valid(ov8), .out_ready(or8), .out_p(p8));

  vedic_mult_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
    .in_a(a4), .in_b(b4), .in_signed(s4),
    .out_valid(ov4), .out_ready(or4), .out_p(p4));

  vedic_mult_pipe #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
    .in_a(a2), .in_b(b2), .in_signed(s2),
    .out_valid(ov2), .out_ready(or2), .out_p(p2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t tv[13];

  task automatic sweep(input int w);
    int n, total, idx, cyc, ai, bi, pair, md;
    bit acc, ov, ir, vv;
    logic [15:0] pv, e;
    logic [15:0] q[$];
    n = (w == 4) ? 16 : 4;
    total = n * n * 2;
    idx = 0;
    cyc = 0;
    acc = 0;
    while ((idx < total || q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (acc) idx++;
      vv = (idx < total);
      md = idx / (n * n);
      pair = idx % (n * n);
      ai = pair / n;
      bi = pair % n;
      if (w == 4) begin
        v4 = vv; a4 = 4'(ai); b4 = 4'(bi); s4 = md[0];
        or4 = ($urandom_range(0, 3) != 0);
      end else begin
        v2 = vv; a2 = 2'(ai); b2 = 2'(bi); s2 = md[0];
        or2 = ($urandom_range(0, 3) != 0);
      end
      #1;
      ov = (w == 4) ? ov4 : ov2;
      ir = (w == 4) ? r4 : r2;
      pv = (w == 4) ? 16'(p4) : 16'(p2);
      acc = vv && ir;
      if (acc) begin
        if (md[0] && ai >= n / 2) ai = ai - n;
        if (md[0] && bi >= n / 2) bi = bi - n;
        e = 16'((ai * bi) & (n * n - 1));
        q.push_back(e);
      end
      if (ov && ((w == 4) ? or4 : or2)) begin
        if (q.size() == 0) chk("sweep_extra_valid", 16'(ov), 16'(0));
        else begin
          e = q.pop_front();
          chk((w == 4) ? "sweep_w4" : "sweep_w2", pv, e);
        end
      end
    end
    if (cyc >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sweep_timeout w=%0d: got idx %0d, want %0d", w, idx, total);
    end
    @(negedge clk);
    v4 = 0; v2 = 0; or4 = 1; or2 = 1;
  endtask

  initial begin
    rst = 1;
    v8 = 0; a8 = 0; b8 = 0; s8 = 0; or8 = 1;
    v4 = 0; a4 = 0; b4 = 0; s4 = 0; or4 = 1;
    v2 = 0; a2 = 0; b2 = 0; s2 = 0; or2 = 1;

    tv[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tv[1]  = '{8'h00, 8'hC8, 1'b0, 16'h0000};
    tv[2]  = '{8'h80, 8'h02, 1'b0, 16'h0100};
    tv[3]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tv[4]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tv[5]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tv[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tv[7]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    tv[8]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    tv[9]  = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};
    tv[10] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    tv[11] = '{8'h85, 8'h0A, 1'b1, 16'hFB32};
    tv[12] = '{8'hC8, 8'hC8, 1'b1, 16'h0C40};

    repeat (3) @(negedge clk);
    chk("reset_out_valid", 16'(ov8), 16'(0));
    chk("reset_out_p", p8, 16'h0000);
    rst = 0;

    // Back-to-back table beats; beat c is driven after negedge c
    // and must be on the output at negedge c+3.
    for (int c = 0; c < 13 + 4; c++) begin
      @(negedge clk);
      chk("tbl_in_ready", 16'(r8), 16'(1));
      if (c >= 3 && c - 3 < 13) begin
        chk("tbl_out_valid", 16'(ov8), 16'(1));
        chk($sformatf("tbl_p[%0d]", c - 3), p8, tv[c - 3].p);
      end else begin
        chk("tbl_idle_valid", 16'(ov8), 16'(0));
      end
      if (c < 13) begin
        v8 = 1; a8 = tv[c].a; b8 = tv[c].b; s8 = tv[c].s;
      end else begin
        v8 = 0;
      end
    end

    // Back-pressure: A,B,C fill the pipe, D waits at the input.
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c < 3) begin
        chk("bp_fill_valid", 16'(ov8), 16'(0));
        chk("bp_fill_ready", 16'(r8), 16'(1));
      end else if (c <= 8) begin
        chk("bp_stall_valid", 16'(ov8), 16'(1));
        chk("bp_stall_p", p8, 16'h00E1);
        chk("bp_stall_ready", 16'(r8), 16'(0));
      end else if (c == 9) begin
        chk("bp_b_valid", 16'(ov8), 16'(1));
        chk("bp_b_p", p8, 16'hFFE0);
      end else if (c == 10) begin
        chk("bp_c_valid", 16'(ov8), 16'(1));
        chk("bp_c_p", p8, 16'h0100);
      end else if (c == 11) begin
        chk("bp_d_valid", 16'(ov8), 16'(1));
        chk("bp_d_p", p8, 16'h3F01);
      end else begin
        chk("bp_no_extra", 16'(ov8), 16'(0));
      end
      case (c)
        0: begin v8 = 1; a8 = 8'h0F; b8 = 8'h0F; s8 = 0; or8 = 0; end
        1: begin a8 = 8'hF0; b8 = 8'h02; s8 = 1; end
        2: begin a8 = 8'h10; b8 = 8'h10; s8 = 0; end
        3: begin a8 = 8'h81; b8 = 8'h81; s8 = 1; end
        8: or8 = 1;
        9: v8 = 0;
        default: ;
      endcase
    end

    // Reset with the pipe full; a beat offered at the reset edge
    // must also be dropped.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("rst_pre_valid", 16'(ov8), 16'(1));
        chk("rst_pre_p", p8, 16'h000F);
      end else if (c == 4) begin
        chk("rst_out_valid", 16'(ov8), 16'(0));
        chk("rst_out_p", p8, 16'h0000);
        chk("rst_in_ready", 16'(r8), 16'(1));
      end else if (c > 4) begin
        chk("rst_no_stale", 16'(ov8), 16'(0));
      end
      case (c)
        0: begin v8 = 1; a8 = 8'h03; b8 = 8'h05; s8 = 0; end
        1: begin a8 = 8'h22; b8 = 8'h11; s8 = 0; end
        2: begin a8 = 8'h90; b8 = 8'h07; s8 = 1; end
        3: begin rst = 1; a8 = 8'h44; b8 = 8'h44; end
        4: begin rst = 0; v8 = 0; end
        default: ;
      endcase
    end

    sweep(4);
    sweep(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
